// File: rtl/control_miscare_pwm_if.sv
// Purpose: groups the sensor/mode inputs and the motor/indicator outputs of control_miscare_pwm.
// Ports: master = stimulus side (drives senzori/circuit/tinta_ture), slave = controller side.
// Widths follow N_SENZ, DC_W and TURE_W, which must match the controller instance.
interface control_miscare_pwm_if #(
    parameter int N_SENZ = 5,
    parameter int DC_W   = 12,
    parameter int TURE_W = 8
);
    logic [N_SENZ-1:0] senzori;
    logic [1:0]        circuit;
    logic [TURE_W-1:0] tinta_ture;
    logic [1:0]        directie_driverA;
    logic [1:0]        directie_driverB;
    logic [DC_W-1:0]   factor_dc_driverA;
    logic [DC_W-1:0]   factor_dc_driverB;
    logic              semnal_dreapta;
    logic              semnal_stanga;
    logic              stop;
    logic [TURE_W-1:0] count_ture;
    logic              tura_noua;

    modport master (
        output senzori, circuit, tinta_ture,
        input  directie_driverA, directie_driverB, factor_dc_driverA, factor_dc_driverB,
        input  semnal_dreapta, semnal_stanga, stop, count_ture, tura_noua
    );

    modport slave (
        input  senzori, circuit, tinta_ture,
        output directie_driverA, directie_driverB, factor_dc_driverA, factor_dc_driverB,
        output semnal_dreapta, semnal_stanga, stop, count_ture, tura_noua
    );
endinterface

// File: rtl/control_miscare_pwm.sv
// Purpose: line-follower motion controller: sensor bar -> H-bridge direction/duty, lost-line search, lap counter.
// Latency: sensor pin change reaches outputs on the 3rd clk edge (2 sync flops + 1 output register).
// Backpressure: none; free-running, every output registered and updated every cycle.
// Ports: clk, rst_n (async active-low); bus (slave modport) carries senzori/circuit/tinta_ture in and
//        directie_driverA/B, factor_dc_driverA/B, semnal_dreapta/stanga, stop, count_ture, tura_noua out.
module control_miscare_pwm #(
    parameter int              N_SENZ     = 5,
    parameter int              DC_W       = 12,
    parameter logic [DC_W-1:0] DC_MAX     = 12'h998,
    parameter logic [DC_W-1:0] DC_CURBA   = 12'h650,
    parameter logic [DC_W-1:0] DC_CAUTARE = 12'h800,
    parameter int              DEB        = 4,
    parameter int              LOST_MAX   = 1000,
    parameter int              TURE_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    control_miscare_pwm_if.slave bus
);
    localparam int C  = (N_SENZ - 1) / 2;
    localparam int LW = $clog2(LOST_MAX + 1);
    localparam int DW = $clog2(DEB + 1);

    localparam logic [1:0] DIR_FWD = 2'b10;
    localparam logic [1:0] DIR_REV = 2'b01;
    localparam logic [1:0] DIR_BRK = 2'b00;

    typedef enum logic [1:0] {IDLE, URMARIRE, CAUTARE, OPRIT} state_t;
    typedef enum logic [1:0] {MEM_NONE, MEM_DREAPTA, MEM_STANGA} mem_t;

    logic [N_SENZ-1:0] r_sync1, r_s;
    state_t            r_state, w_state_nx;
    mem_t              r_mem, w_mem_nx;
    logic [LW-1:0]     r_lost, w_lost_nx;
    logic [DW-1:0]     r_deb_hi, w_deb_hi_nx, r_deb_lo, w_deb_lo_nx;
    logic              r_armed, w_armed_nx;
    logic [TURE_W-1:0] r_count, w_count_nx;
    logic              r_tura, w_tura_nx;
    logic [1:0]        r_dir_a, r_dir_b, w_dir_a, w_dir_b;
    logic [DC_W-1:0]   r_dc_a, r_dc_b, w_dc_a, w_dc_b;
    logic              r_stop, w_stop;
    logic              r_sem_d, r_sem_s;

    logic              w_r, w_l, w_m, w_both_hi, w_both_lo, w_lap_stop, w_active;
    logic [TURE_W-1:0] w_target;

    assign w_r       = |r_s[C-1:1];
    assign w_l       = |r_s[N_SENZ-2:C+1];
    assign w_m       = r_s[C];
    assign w_both_hi = r_s[0] & r_s[N_SENZ-1];
    assign w_both_lo = ~r_s[0] & ~r_s[N_SENZ-1];
    assign w_active  = (r_state == URMARIRE) || (r_state == CAUTARE);
    assign w_target  = (bus.tinta_ture == '0) ? TURE_W'(1) : bus.tinta_ture;

    // r_tura is high exactly on the cycle after a lap was counted, so r_count is already the new count.
    assign w_lap_stop = r_tura &&
                        (((bus.circuit == 2'b01) && (r_count >= TURE_W'(1))) ||
                         ((bus.circuit == 2'b10) && (r_count >= w_target)));

    // Next state, line memory and lost-line counter.
    always_comb begin
        w_state_nx = r_state;
        w_mem_nx   = r_mem;
        w_lost_nx  = r_lost;
        case (r_state)
            IDLE: begin
                if (bus.circuit != 2'b00) w_state_nx = URMARIRE;
            end
            URMARIRE: begin
                if (!w_r && !w_l && !w_m) begin
                    w_state_nx = CAUTARE;
                    w_lost_nx  = '0;
                end
            end
            CAUTARE: begin
                if (w_r || w_l || w_m) begin
                    w_state_nx = URMARIRE;
                    w_lost_nx  = '0;
                end else if (r_lost == LW'(LOST_MAX)) begin
                    w_state_nx = OPRIT;
                end else begin
                    w_lost_nx = r_lost + LW'(1);
                end
            end
            default: ;
        endcase
        if (w_lap_stop && w_active) w_state_nx = OPRIT;
        if (bus.circuit == 2'b00)   w_state_nx = IDLE;

        if (w_state_nx == IDLE)
            w_mem_nx = MEM_NONE;
        else if (w_state_nx == URMARIRE && (w_r ^ w_l))
            w_mem_nx = w_r ? MEM_DREAPTA : MEM_STANGA;
    end

    // Outputs are computed for the state being entered so they change on the same edge as the state.
    always_comb begin
        w_dir_a = DIR_BRK;
        w_dir_b = DIR_BRK;
        w_dc_a  = '0;
        w_dc_b  = '0;
        w_stop  = 1'b1;
        case (w_state_nx)
            URMARIRE: begin
                w_dir_a = DIR_FWD;
                w_dir_b = DIR_FWD;
                w_dc_a  = DC_MAX;
                w_dc_b  = DC_MAX;
                w_stop  = ~w_m;
                // The wheel on the side that sees the line reverses to pivot back onto it.
                if (w_r && !w_l) begin
                    w_dir_a = DIR_REV;
                    w_dc_a  = w_m ? DC_CURBA : DC_CAUTARE;
                end else if (w_l && !w_r) begin
                    w_dir_b = DIR_REV;
                    w_dc_b  = w_m ? DC_CURBA : DC_CAUTARE;
                end
            end
            CAUTARE: begin
                w_dir_a = (w_mem_nx == MEM_DREAPTA) ? DIR_REV : DIR_FWD;
                w_dir_b = (w_mem_nx == MEM_STANGA)  ? DIR_REV : DIR_FWD;
                w_dc_a  = DC_MAX;
                w_dc_b  = DC_MAX;
            end
            default: ;
        endcase
    end

    // Finish-line debounce: both markers high for DEB cycles counts once, both low for DEB re-arms.
    always_comb begin
        w_deb_hi_nx = r_deb_hi;
        w_deb_lo_nx = r_deb_lo;
        w_armed_nx  = r_armed;
        w_count_nx  = r_count;
        w_tura_nx   = 1'b0;
        if (w_state_nx == IDLE) begin
            w_deb_hi_nx = '0;
            w_deb_lo_nx = '0;
            w_armed_nx  = 1'b1;
            w_count_nx  = '0;
        end else if (w_active) begin
            if (w_both_hi) begin
                w_deb_lo_nx = '0;
                if (r_armed && r_deb_hi == DW'(DEB - 1)) begin
                    w_deb_hi_nx = '0;
                    w_armed_nx  = 1'b0;
                    w_tura_nx   = 1'b1;
                    if (r_count != '1) w_count_nx = r_count + TURE_W'(1);
                end else if (r_deb_hi != DW'(DEB - 1)) begin
                    w_deb_hi_nx = r_deb_hi + DW'(1);
                end
            end else if (w_both_lo) begin
                w_deb_hi_nx = '0;
                if (!r_armed && r_deb_lo == DW'(DEB - 1)) begin
                    w_deb_lo_nx = '0;
                    w_armed_nx  = 1'b1;
                end else if (r_deb_lo != DW'(DEB - 1)) begin
                    w_deb_lo_nx = r_deb_lo + DW'(1);
                end
            end else begin
                w_deb_hi_nx = '0;
                w_deb_lo_nx = '0;
            end
        end else begin
            w_deb_hi_nx = '0;
            w_deb_lo_nx = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '0;
            r_s      <= '0;
            r_state  <= IDLE;
            r_mem    <= MEM_NONE;
            r_lost   <= '0;
            r_deb_hi <= '0;
            r_deb_lo <= '0;
            r_armed  <= 1'b1;
            r_count  <= '0;
            r_tura   <= 1'b0;
            r_dir_a  <= DIR_BRK;
            r_dir_b  <= DIR_BRK;
            r_dc_a   <= '0;
            r_dc_b   <= '0;
            r_stop   <= 1'b1;
            r_sem_d  <= 1'b0;
            r_sem_s  <= 1'b0;
        end else begin
            r_sync1  <= bus.senzori;
            r_s      <= r_sync1;
            r_state  <= w_state_nx;
            r_mem    <= w_mem_nx;
            r_lost   <= w_lost_nx;
            r_deb_hi <= w_deb_hi_nx;
            r_deb_lo <= w_deb_lo_nx;
            r_armed  <= w_armed_nx;
            r_count  <= w_count_nx;
            r_tura   <= w_tura_nx;
            r_dir_a  <= w_dir_a;
            r_dir_b  <= w_dir_b;
            r_dc_a   <= w_dc_a;
            r_dc_b   <= w_dc_b;
            r_stop   <= w_stop;
            r_sem_d  <= r_s[0];
            r_sem_s  <= r_s[N_SENZ-1];
        end
    end

    assign bus.directie_driverA  = r_dir_a;
    assign bus.directie_driverB  = r_dir_b;
    assign bus.factor_dc_driverA = r_dc_a;
    assign bus.factor_dc_driverB = r_dc_b;
    assign bus.stop              = r_stop;
    assign bus.semnal_dreapta    = r_sem_d;
    assign bus.semnal_stanga     = r_sem_s;
    assign bus.count_ture        = r_count;
    assign bus.tura_noua         = r_tura;
endmodule

// File: tb/tb_control_miscare_pwm.sv
// Purpose: directed + randomized bench for control_miscare_pwm (N_SENZ=5, DEB=4, LOST_MAX=8).
// Latency: expectations sampled 1 time unit after rising edges; sensor effects expected on the 3rd edge.
// Backpressure: none; the bench drives inputs freely between edges.
module tb_control_miscare_pwm;
    localparam int DEB      = 4;
    localparam int LOST_MAX = 8;
    localparam logic [11:0] DMAX = 12'h998;
    localparam logic [11:0] DCUR = 12'h650;
    localparam logic [11:0] DCAU = 12'h800;
    localparam logic [4:0]  P_HI = 5'b10101;
    localparam logic [4:0]  P_LO = 5'b00100;

    logic clk = 1'b0;
    logic rst_n;
    int   nchk = 0, npass = 0, nfail = 0;

    always #5 clk = ~clk;

    control_miscare_pwm_if #(.N_SENZ(5), .DC_W(12), .TURE_W(8)) bus_if ();

    control_miscare_pwm #(
        .N_SENZ(5), .DC_W(12), .DC_MAX(DMAX), .DC_CURBA(DCUR), .DC_CAUTARE(DCAU),
        .DEB(DEB), .LOST_MAX(LOST_MAX), .TURE_W(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_drive(input string tag, input logic [1:0] ea, input logic [1:0] eb,
                               input logic [11:0] dca, input logic [11:0] dcb, input logic st);
        check({tag, ".dirA"}, 32'(bus_if.directie_driverA), 32'(ea));
        check({tag, ".dirB"}, 32'(bus_if.directie_driverB), 32'(eb));
        check({tag, ".dcA"},  32'(bus_if.factor_dc_driverA), 32'(dca));
        check({tag, ".dcB"},  32'(bus_if.factor_dc_driverB), 32'(dcb));
        check({tag, ".stop"}, 32'(bus_if.stop), 32'(st));
    endtask

    // Search behaviour: keep turning toward the side where the line was last seen.
    task automatic check_search(input string tag, input int side);
        check_drive(tag, (side == 1) ? 2'b01 : 2'b10, (side == 2) ? 2'b01 : 2'b10, DMAX, DMAX, 1'b1);
    endtask

    task automatic run_phase(input logic [4:0] pat, input int len, output int pulses);
        pulses = 0;
        bus_if.senzori = pat;
        repeat (len) begin
            tick();
            if (bus_if.tura_noua === 1'b1) pulses++;
        end
    endtask

    initial begin
        logic [4:0]  p;
        logic [2:0]  t;
        logic [1:0]  ea, eb;
        logic [11:0] dca, dcb;
        int          side, mk, p1, p2, h, l, mcount, extra;
        bit          marmed, exp_lap;

        rst_n = 1'b0;
        bus_if.senzori = '0;
        bus_if.circuit = 2'b00;
        bus_if.tinta_ture = '0;
        #12;
        check_drive("reset", 2'b00, 2'b00, 12'h0, 12'h0, 1'b1);
        check("reset.semD", 32'(bus_if.semnal_dreapta), 0);
        check("reset.semS", 32'(bus_if.semnal_stanga), 0);
        check("reset.count", 32'(bus_if.count_ture), 0);
        check("reset.tura", 32'(bus_if.tura_noua), 0);
        #10;
        rst_n = 1'b1;

        // Centre on line, endurance mode.
        bus_if.circuit = 2'b11;
        bus_if.senzori = 5'b00100;
        ticks(3);
        check_drive("centre", 2'b10, 2'b10, DMAX, DMAX, 1'b0);

        // Lost line with no memory, recovered before the timeout.
        bus_if.senzori = 5'b00000;
        ticks(3);
        check_search("search_none", 0);
        bus_if.senzori = 5'b00100;
        ticks(3);
        check_drive("recover", 2'b10, 2'b10, DMAX, DMAX, 1'b0);

        // Right tracking with centre: exact 3-edge latency.
        bus_if.senzori = 5'b00110;
        ticks(2);
        check("lat.edge2", 32'(bus_if.directie_driverA), 32'(2'b10));
        tick();
        check_drive("right_centre", 2'b01, 2'b10, DCUR, DMAX, 1'b0);

        // Lose the line: search right, then stop LOST_MAX+1 edges after entering the search.
        bus_if.senzori = 5'b00000;
        ticks(3);
        check_search("search_right", 1);
        ticks(LOST_MAX);
        check("timeout.before", 32'(bus_if.directie_driverA), 32'(2'b01));
        tick();
        check_drive("timeout", 2'b00, 2'b00, 12'h0, 12'h0, 1'b1);
        bus_if.senzori = 5'b00100;
        ticks(4);
        check("oprit.sticky", 32'(bus_if.directie_driverA), 32'(2'b00));

        bus_if.circuit = 2'b00;
        tick();
        check_drive("idle", 2'b00, 2'b00, 12'h0, 12'h0, 1'b1);
        check("idle.count", 32'(bus_if.count_ture), 0);
        bus_if.circuit = 2'b11;
        ticks(3);
        check_drive("restart", 2'b10, 2'b10, DMAX, DMAX, 1'b0);

        // Left tracking without centre.
        bus_if.senzori = 5'b01000;
        ticks(3);
        check_drive("left_off", 2'b10, 2'b01, DMAX, DCAU, 1'b1);
        bus_if.senzori = 5'b00100;
        ticks(3);
        check_drive("left_restore", 2'b10, 2'b10, DMAX, DMAX, 1'b0);

        // Randomized line patterns against the steering rules.
        side = 2;
        for (int i = 0; i < 20; i++) begin
            t  = 3'($urandom_range(1, 7));
            mk = $urandom_range(0, 2);
            p  = {mk == 2, t, mk == 1};
            bus_if.senzori = p;
            ticks(3);
            ea = 2'b10; eb = 2'b10; dca = DMAX; dcb = DMAX;
            if (p[1] && !p[3]) begin
                ea = 2'b01; dca = p[2] ? DCUR : DCAU; side = 1;
            end else if (p[3] && !p[1]) begin
                eb = 2'b01; dcb = p[2] ? DCUR : DCAU; side = 2;
            end
            check_drive($sformatf("rand%0d_%b", i, p), ea, eb, dca, dcb, !p[2]);
            check($sformatf("rand%0d.semD", i), 32'(bus_if.semnal_dreapta), 32'(p[0]));
            check($sformatf("rand%0d.semS", i), 32'(bus_if.semnal_stanga), 32'(p[4]));
        end
        bus_if.senzori = 5'b00000;
        ticks(3);
        check_search("search_mem", side);
        bus_if.senzori = 5'b00100;
        ticks(3);

        // Target-lap mode: glitch ignored, three laps then stop.
        bus_if.circuit = 2'b10;
        bus_if.tinta_ture = 8'd3;
        run_phase(P_HI, 3, p1);
        run_phase(P_LO, 6, p2);
        check("glitch.pulses", 32'(p1 + p2), 0);
        check("glitch.count", 32'(bus_if.count_ture), 0);
        for (int k = 1; k <= 3; k++) begin
            bus_if.senzori = P_HI;
            ticks(DEB + 1);
            check($sformatf("lap%0d.early", k), 32'(bus_if.count_ture), 32'(k - 1));
            tick();
            check($sformatf("lap%0d.tura", k), 32'(bus_if.tura_noua), 1);
            check($sformatf("lap%0d.count", k), 32'(bus_if.count_ture), 32'(k));
            bus_if.senzori = P_LO;
            tick();
            check($sformatf("lap%0d.pulse_end", k), 32'(bus_if.tura_noua), 0);
            if (k == 3) check_drive("lap_stop", 2'b00, 2'b00, 12'h0, 12'h0, 1'b1);
            else        check($sformatf("lap%0d.running", k), 32'(bus_if.directie_driverA), 32'(2'b10));
            ticks(5);
        end

        // Target of zero behaves as one.
        bus_if.circuit = 2'b00;
        tick();
        bus_if.circuit = 2'b10;
        bus_if.tinta_ture = 8'd0;
        ticks(3);
        bus_if.senzori = P_HI;
        ticks(DEB + 2);
        check("tinta0.count", 32'(bus_if.count_ture), 1);
        bus_if.senzori = P_LO;
        tick();
        check("tinta0.stop", 32'(bus_if.directie_driverA), 32'(2'b00));

        // Marker held for 50 cycles counts once.
        bus_if.circuit = 2'b00;
        tick();
        check("clear.count", 32'(bus_if.count_ture), 0);
        bus_if.circuit = 2'b11;
        ticks(3);
        run_phase(P_HI, 50, p1);
        check("hold.pulses", 32'(p1), 1);
        check("hold.count", 32'(bus_if.count_ture), 1);
        check("hold.semD", 32'(bus_if.semnal_dreapta), 1);
        check("hold.semS", 32'(bus_if.semnal_stanga), 1);
        run_phase(P_LO, 6, p2);
        check("hold.release", 32'(bus_if.semnal_dreapta), 0);

        // Random marker crossings in endurance mode up to and past saturation.
        mcount = 1;
        marmed = 1'b1;
        extra  = 0;
        for (int it = 0; it < 4000 && extra < 3; it++) begin
            h = $urandom_range(1, DEB + 3);
            l = $urandom_range(2, DEB + 3);
            run_phase(P_HI, h, p1);
            run_phase(P_LO, l, p2);
            exp_lap = marmed && (h >= DEB);
            if (exp_lap) marmed = 1'b0;
            if (l >= DEB) marmed = 1'b1;
            if (mcount < 255) begin
                check($sformatf("xing%0d.pulses", it), 32'(p1 + p2), 32'(exp_lap));
                if (exp_lap) mcount++;
            end else if (exp_lap) begin
                extra++;
            end
            check($sformatf("xing%0d.count", it), 32'(bus_if.count_ture), 32'(mcount));
        end
        check("sat.count", 32'(bus_if.count_ture), 32'd255);
        check("sat.running", 32'(bus_if.directie_driverA), 32'(2'b10));

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
